// File: rtl/if_id_skid_stage.sv
// ---------------------------------------------------------------------------
// if_id_skid_stage
// Fetch/decode pipeline register with a valid/ready handshake and a
// two-entry skid buffer. Fetch can keep running while decode stalls.
// in_ready comes from registered occupancy only, so there is no
// combinational path from decode (out_ready) or flush back to fetch.
//
// Optional build macro: IF_ID_PERF_EN adds saturating stall/flush counters.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   flush      discard all held entries (branch/trap redirect)
//   in_valid   fetch presents {in_pc, in_instr}
//   in_ready   stage can accept (registered occupancy, gated by rst_n)
//   in_pc      fetch PC+2
//   in_instr   instruction memory read data
//   out_valid  head entry available to decode
//   out_ready  decode consumes head entry
//   out_pc     head PC (0 when empty)
//   out_instr  head instruction (NOP_INSTR when empty)
//   stall_cnt  [IF_ID_PERF_EN] cycles with out_valid & !out_ready & !flush
//   flush_cnt  [IF_ID_PERF_EN] flushes that discarded at least one entry
// ---------------------------------------------------------------------------
module if_id_skid_stage #(
    parameter int                 PC_W      = 16,
    parameter int                 INSTR_W   = 16,
    parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
    parameter int                 CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr
`ifdef IF_ID_PERF_EN
    ,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
`endif
);

    // Occupancy: ONE = main valid, TWO = main and skid valid.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [PC_W-1:0]    r_main_pc,    r_skid_pc;
    logic [INSTR_W-1:0] r_main_instr, r_skid_instr;

    logic w_in_fire, w_out_fire;
    logic w_main_ld, w_main_from_skid, w_skid_ld;

    assign in_ready   = (r_state != S_TWO) & rst_n;
    assign out_valid  = (r_state != S_EMPTY);
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    assign out_pc    = out_valid ? r_main_pc    : '0;
    assign out_instr = out_valid ? r_main_instr : NOP_INSTR;

    // Next-state and load enables.
    always_comb begin
        w_state_nxt      = r_state;
        w_main_ld        = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_ld        = 1'b0;
        if (flush) begin
            // Anything accepted this cycle is discarded with the rest.
            w_state_nxt = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_in_fire) begin
                        w_state_nxt = S_ONE;
                        w_main_ld   = 1'b1;
                    end
                end
                S_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        w_main_ld = 1'b1;
                    end else if (w_in_fire) begin
                        // Head is stuck; park the younger entry in skid.
                        w_state_nxt = S_TWO;
                        w_skid_ld   = 1'b1;
                    end else if (w_out_fire) begin
                        w_state_nxt = S_EMPTY;
                    end
                end
                S_TWO: begin
                    // in_ready is low here, so only a drain can happen.
                    if (w_out_fire) begin
                        w_state_nxt      = S_ONE;
                        w_main_ld        = 1'b1;
                        w_main_from_skid = 1'b1;
                    end
                end
                default: w_state_nxt = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_EMPTY;
            r_main_pc    <= '0;
            r_main_instr <= NOP_INSTR;
            r_skid_pc    <= '0;
            r_skid_instr <= NOP_INSTR;
        end else begin
            r_state <= w_state_nxt;
            if (w_main_ld) begin
                r_main_pc    <= w_main_from_skid ? r_skid_pc    : in_pc;
                r_main_instr <= w_main_from_skid ? r_skid_instr : in_instr;
            end
            if (w_skid_ld) begin
                r_skid_pc    <= in_pc;
                r_skid_instr <= in_instr;
            end
        end
    end

`ifdef IF_ID_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
    logic             w_stall_inc, w_flush_inc;

    assign w_stall_inc = out_valid & ~out_ready & ~flush;
    assign w_flush_inc = flush & (r_state != S_EMPTY);

    // Both counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_inc && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (w_flush_inc && (r_flush_cnt != {CNT_W{1'b1}}))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    // Counter width only matters when the counters are built.
    logic [31:0] w_unused_cnt_w;
    assign w_unused_cnt_w = 32'(CNT_W);
`endif

endmodule

// File: tb/tb_if_id_skid_stage.sv
module tb_if_id_skid_stage;

    localparam int PC_W    = 16;
    localparam int INSTR_W = 16;
    localparam int CNT_W   = 4;
    localparam logic [INSTR_W-1:0] NOP = 16'h0000;

    logic               clk = 1'b0;
    logic               rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [PC_W-1:0]    in_pc, out_pc;
    logic [INSTR_W-1:0] in_instr, out_instr;
`ifdef IF_ID_PERF_EN
    logic [CNT_W-1:0]   stall_cnt, flush_cnt;
`endif

    int total = 0;
    int bad   = 0;

    if_id_skid_stage #(
        .PC_W(PC_W), .INSTR_W(INSTR_W), .NOP_INSTR(NOP), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr)
`ifdef IF_ID_PERF_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- reference model: a bounded FIFO of depth 2 ----------
    typedef struct {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } ent_t;

    ent_t m_q[$];
    int   m_stall = 0;
    int   m_flush = 0;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    // Inputs change only just after negedge, so they are stable here.
    always @(posedge clk) begin
        bit inf, outf;
        if (!rst_n) begin
            m_q.delete();
            m_stall = 0;
            m_flush = 0;
        end else begin
            inf  = in_valid && (m_q.size() < 2);
            outf = out_ready && (m_q.size() > 0);
            if (m_q.size() > 0 && !out_ready && !flush && m_stall < CNT_MAX) m_stall++;
            if (flush && m_q.size() > 0 && m_flush < CNT_MAX) m_flush++;
            if (flush) begin
                m_q.delete();
            end else begin
                if (outf) void'(m_q.pop_front());
                if (inf) m_q.push_back('{pc: in_pc, instr: in_instr});
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        logic        e_rdy, e_vld;
        logic [15:0] e_pc, e_instr;
        e_rdy   = (m_q.size() < 2) && (rst_n === 1'b1);
        e_vld   = (m_q.size() > 0);
        e_pc    = e_vld ? m_q[0].pc    : 16'h0;
        e_instr = e_vld ? m_q[0].instr : NOP;
        chk("model_in_ready",  32'(in_ready),  32'(e_rdy));
        chk("model_out_valid", 32'(out_valid), 32'(e_vld));
        chk("model_out_pc",    32'(out_pc),    32'(e_pc));
        chk("model_out_instr", 32'(out_instr), 32'(e_instr));
`ifdef IF_ID_PERF_EN
        chk("model_stall_cnt", 32'(stall_cnt), 32'(m_stall));
        chk("model_flush_cnt", 32'(flush_cnt), 32'(m_flush));
`endif
    end

    // Advance one cycle; return just after the following negedge compare.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] pc, input logic [15:0] ins,
                         input logic ordy, input logic fl);
        in_valid  = v;
        in_pc     = pc;
        in_instr  = ins;
        out_ready = ordy;
        flush     = fl;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b1, 16'h1234, 16'hABCD, 1'b1, 1'b0);

        // Reset held for two cycles with fetch offering.
        step(); step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_pc",    32'(out_pc),    32'h0);
        chk("rst_out_instr", 32'(out_instr), 32'h0000);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        rst_n = 1'b1;
        drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        step();
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Single transfer, one-cycle latency.
        drive(1'b1, 16'h3002, 16'h1021, 1'b1, 1'b0);
        step();
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_pc",    32'(out_pc),    32'h3002);
        chk("single_instr", 32'(out_instr), 32'h1021);
        drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        step();
        chk("single_drained", 32'(out_valid), 32'd0);

        // Back-to-back streaming.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 16'(16'h3100 + 2*i), 16'(16'h0111 * i), 1'b1, 1'b0);
            step();
            chk("stream_pc",    32'(out_pc),    32'(16'h3100 + 2*i));
            chk("stream_instr", 32'(out_instr), 32'(16'h0111 * i));
            chk("stream_rdy",   32'(in_ready),  32'd1);
        end
        drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        step();

        // Skid fill: A then B while decode stalls, C held off.
        drive(1'b1, 16'h3002, 16'h1021, 1'b0, 1'b0);
        step();
        drive(1'b1, 16'h3004, 16'h5260, 1'b0, 1'b0);
        step();
        chk("skid_full_rdy", 32'(in_ready), 32'd0);
        chk("skid_head_pc",  32'(out_pc),   32'h3002);
        drive(1'b1, 16'h3006, 16'h3FFF, 1'b0, 1'b0);
        step(); step();
        chk("skid_hold_pc",    32'(out_pc),    32'h3002);
        chk("skid_hold_instr", 32'(out_instr), 32'h1021);
        chk("skid_hold_rdy",   32'(in_ready),  32'd0);
        // Drain: A, B, C on consecutive cycles.
        out_ready = 1'b1;
        step();
        chk("drain_b_pc",    32'(out_pc),    32'h3004);
        chk("drain_b_instr", 32'(out_instr), 32'h5260);
        step();
        chk("drain_c_pc",    32'(out_pc),    32'h3006);
        chk("drain_c_instr", 32'(out_instr), 32'h3FFF);
        drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        step();
        chk("drain_empty", 32'(out_valid), 32'd0);

        // Flush while TWO (in_ready low so no accept is possible).
        drive(1'b1, 16'h4000, 16'h0AAA, 1'b0, 1'b0);
        step();
        drive(1'b1, 16'h4002, 16'h0BBB, 1'b0, 1'b0);
        step();
        drive(1'b1, 16'h4004, 16'h0CCC, 1'b0, 1'b1);
        step();
        chk("flush_two_valid", 32'(out_valid), 32'd0);
        // Flush in ONE with a simultaneous accept of D.
        drive(1'b1, 16'h5000, 16'h0EEE, 1'b0, 1'b0);
        step();
        drive(1'b1, 16'h5002, 16'h0DDD, 1'b0, 1'b1);
        step();
        chk("flush_one_valid", 32'(out_valid), 32'd0);
        chk("flush_one_instr", 32'(out_instr), 32'h0000);
        drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        step();
        chk("flush_d_dropped", 32'(out_valid), 32'd0);
`ifdef IF_ID_PERF_EN
        chk("flush_cnt_lit", 32'(flush_cnt), 32'd2);
`endif

        // Reset in the middle of TWO drops both entries.
        drive(1'b1, 16'h6000, 16'h0123, 1'b0, 1'b0);
        step();
        drive(1'b1, 16'h6002, 16'h0456, 1'b0, 1'b0);
        step();
        rst_n = 1'b0;
        step();
        chk("rst_two_valid", 32'(out_valid), 32'd0);
        chk("rst_two_rdy",   32'(in_ready),  32'd0);
        rst_n = 1'b1;
        drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        step();
        chk("rst_two_empty", 32'(out_valid), 32'd0);

        // Long stall: counter saturates at 15 with a 4-bit width.
        drive(1'b1, 16'h7000, 16'h0F0F, 1'b0, 1'b0);
        step();
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step();
        chk("stall_hold_pc", 32'(out_pc), 32'h7000);
`ifdef IF_ID_PERF_EN
        chk("stall_cnt_sat", 32'(stall_cnt), 32'd15);
`endif
        out_ready = 1'b1;
        step();
        chk("stall_release", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
